// File: rtl/disparity_range_checker.sv
// Self-test monitor for the disparity stream: counts in-window pixels over a raster of
// FRAMES frames after a start-qualified warm-up and reports pass/fail/done.
module disparity_range_checker #(
  parameter int unsigned DISP_W   = 7,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned FRAMES   = 1,
  parameter int unsigned WARMUP   = 50000,
  parameter int unsigned CNT_W    = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [DISP_W-1:0] cfg_lo,
  input  logic [DISP_W-1:0] cfg_hi,
  input  logic [CNT_W-1:0]  cfg_pass,
  input  logic              pix_valid,
  input  logic [DISP_W-1:0] result,
  output logic              flag,
  output logic              fail,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WARMUP - 1);

  typedef enum logic [1:0] {StIdle, StWarmup, StRun, StDone} state_e;

  state_e             state_q;
  logic [DISP_W-1:0]  lo_q, hi_q;
  logic [CNT_W-1:0]   pass_q;
  logic [WW-1:0]      warm_q;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [FW-1:0]      fr_q;

  logic               hit, last_x, last_y, last_pix;
  logic [CNT_W-1:0]   hit_next;

  always_comb begin
    hit      = (result >= lo_q) && (result <= hi_q);
    last_x   = (x_q == X_LAST);
    last_y   = (y_q == Y_LAST);
    last_pix = last_x && last_y && (fr_q == F_LAST);
    hit_next = hit_count;
    if (pix_valid && hit && (hit_count != {CNT_W{1'b1}})) begin
      hit_next = hit_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q   <= StIdle;
      lo_q      <= '0;
      hi_q      <= '0;
      pass_q    <= '0;
      warm_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fr_q      <= '0;
      flag      <= 1'b0;
      fail      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      hit_count <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lo_q      <= cfg_lo;
            hi_q      <= cfg_hi;
            pass_q    <= cfg_pass;
            warm_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fr_q      <= '0;
            hit_count <= '0;
            frame_cnt <= '0;
            flag      <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b1;
            state_q   <= (WARMUP == 0) ? StRun : StWarmup;
          end
        end
        StWarmup: begin
          if (start) begin
            if (warm_q == W_LAST) begin
              state_q <= StRun;
            end else begin
              warm_q <= warm_q + 1'b1;
            end
          end
        end
        StRun: begin
          hit_count <= hit_next;
          // Registered count term covers cfg_pass==0; next-count term sets flag on the hit edge.
          if ((hit_count == pass_q) || (hit_next == pass_q)) begin
            flag <= 1'b1;
          end
          if (pix_valid) begin
            if (last_x) begin
              x_q <= '0;
              if (last_y) begin
                y_q  <= '0;
                fr_q <= fr_q + 1'b1;
                if (frame_cnt != 8'hFF) begin
                  frame_cnt <= frame_cnt + 8'd1;
                end
              end else begin
                y_q <= y_q + 1'b1;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
            if (last_pix) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          fail <= ~flag;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_disparity_range_checker.sv
// Randomized directed bench for disparity_range_checker against a pixel-index level model.
module tb_disparity_range_checker;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FR = 2;
  localparam int WU = 4;
  localparam int CW = 4;
  localparam int PIX = H * V * FR;
  localparam int HMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, clear, pix_valid;
  logic [6:0]    cfg_lo, cfg_hi, result;
  logic [CW-1:0] cfg_pass;
  logic          flag, fail, done, busy;
  logic [CW-1:0] hit_count;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: phase 0 idle, 1 warm-up, 2 run, 3 done.
  int         m_phase, m_warm, m_pix, m_hits, m_pass;
  logic [6:0] m_lo, m_hi;
  bit         m_flag, m_fail;

  disparity_range_checker #(
    .DISP_W  (7),
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .FRAMES  (FR),
    .WARMUP  (WU),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .cfg_pass (cfg_pass),
    .pix_valid(pix_valid),
    .result   (result),
    .flag     (flag),
    .fail     (fail),
    .done     (done),
    .busy     (busy),
    .hit_count(hit_count),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat_hits();
    return (m_hits > HMAX) ? HMAX : m_hits;
  endfunction

  task automatic model(input logic rst, input logic st, input logic cl, input logic pv,
                       input logic [6:0] res);
    if (rst || cl) begin
      m_phase = 0; m_warm = 0; m_pix = 0; m_hits = 0; m_pass = 0;
      m_lo = '0; m_hi = '0; m_flag = 0; m_fail = 0;
    end else begin
      case (m_phase)
        0: if (st) begin
          m_lo = cfg_lo; m_hi = cfg_hi; m_pass = int'(cfg_pass);
          m_warm = 0; m_pix = 0; m_hits = 0; m_flag = 0; m_fail = 0;
          m_phase = (WU == 0) ? 2 : 1;
        end
        1: if (st) begin
          m_warm++;
          if (m_warm == WU) m_phase = 2;
        end
        2: begin
          if (pv) begin
            if (res >= m_lo && res <= m_hi) m_hits++;
            m_pix++;
          end
          if (sat_hits() >= m_pass) m_flag = 1;
          if (m_pix == PIX) m_phase = 3;
        end
        default: m_fail = !m_flag;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int fexp;
    fexp = m_pix / (H * V);
    if (fexp > 255) fexp = 255;
    check("flag", 32'(flag), 32'(m_flag));
    check("fail", 32'(fail), 32'(m_fail));
    check("done", 32'(done), 32'(m_phase == 3));
    check("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    check("hit_count", 32'(hit_count), 32'(sat_hits()));
    check("frame_cnt", 32'(frame_cnt), 32'(fexp));
  endtask

  task automatic step(input logic rst, input logic st, input logic cl, input logic pv,
                      input logic [6:0] res);
    reset = rst; start = st; clear = cl; pix_valid = pv; result = res;
    @(posedge clk);
    model(rst, st, cl, pv, res);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic arm(input logic [6:0] lo, input logic [6:0] hi, input logic [CW-1:0] pass);
    cfg_lo = lo; cfg_hi = hi; cfg_pass = pass;
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    cfg_lo = 7'($urandom); cfg_hi = 7'($urandom); cfg_pass = CW'($urandom);
  endtask

  // Warm-up with random start gating; pix_valid pulses must be ignored.
  task automatic warm_random();
    for (int i = 0; i < 100 && m_phase == 1; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 1'($urandom), 7'($urandom));
    end
  endtask

  // mode 0: any value, 1: out of 16..35 window, 2: in window 0..127
  task automatic feed(input int mode);
    logic [6:0] r;
    for (int i = 0; i < 200 && m_phase == 2; i++) begin
      r = 7'($urandom);
      if (mode == 1) r = 7'($urandom_range(36, 127));
      step(1'b0, 1'($urandom), 1'b0, ($urandom_range(0, 3) != 0), r);
    end
  endtask

  task automatic linger();
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0, 1'($urandom), 7'($urandom));
  endtask

  initial begin
    logic [6:0] seq [8];
    logic       pat [6];
    seq[0] = 7'd16; seq[1] = 7'd35; seq[2] = 7'd15; seq[3] = 7'd36;
    seq[4] = 7'd20; seq[5] = 7'd0;  seq[6] = 7'd0;  seq[7] = 7'd0;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    reset = 1'b1; start = 1'b0; clear = 1'b0; pix_valid = 1'b0; result = '0;
    cfg_lo = '0; cfg_hi = '0; cfg_pass = '0;
    model(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 7'd20);

    // Window 16..35, pass 3: directed edge values first, then random pixels.
    arm(7'd16, 7'd35, 4'd3);
    for (int i = 0; i < 100 && m_phase == 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 7'd20);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, seq[i]);
    feed(0);
    linger();

    // No hits at all: done with fail.
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    arm(7'd16, 7'd35, 4'd3);
    warm_random();
    feed(1);
    linger();

    // Gated warm-up pattern with hitting pixels, then clear+start mid-run, re-arm 0..127.
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    arm(7'd0, 7'd127, 4'd15);
    for (int i = 0; i < 6; i++) step(1'b0, pat[i], 1'b0, 1'b1, 7'd20);
    for (int i = 0; i < 100 && m_phase == 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 7'd20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 7'd50);
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd50);
    arm(7'd0, 7'd127, 4'd15);
    warm_random();
    feed(2);
    linger();

    // cfg_pass=0: flag one edge after entering run with no pixels.
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    arm(7'd16, 7'd35, 4'd0);
    warm_random();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd20);

    // Inverted window: no hits; reset mid-run clears everything.
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    arm(7'd30, 7'd10, 4'd1);
    warm_random();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 7'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b1, 7'd20);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'd20);

    // Fully random runs.
    for (int r = 0; r < 4; r++) begin
      arm(7'($urandom), 7'($urandom), CW'($urandom));
      warm_random();
      feed(0);
      linger();
      step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
